muldiv_hilo: RTL and testbench

- Parametrised HI/LO unit with iterative multiply/divide and a pipeline stall handshake.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO in the execute stage.
- Holds HI/LO architectural state and stalls the pipeline while a multi-cycle operation runs.
- Adds signed/unsigned mult/div, divide, cancel-on-flush and a single-cycle multiply mode, none of which the current single-cycle HI/LO register supports.

---
 rtl/muldiv_hilo.sv | 147 ++++++++++++++
 tb/tb_muldiv_hilo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// HI/LO register unit for the execute stage: MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Divides are always iterative; multiplies are iterative or single-cycle (FAST_MUL).
module muldiv_hilo #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             cancel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] work_hi, work_lo, opnd_q;
    logic             is_div_q, neg_lo_q, neg_hi_q, done_q;

    logic             op_mul, op_div, op_signed;
    logic             issue, accept, fast, launch, last;
    logic             a_neg, b_neg, div_zero;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;

    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign op_mul    = (op_i == 3'd1) || (op_i == 3'd2);
    assign op_div    = (op_i == 3'd3) || (op_i == 3'd4);
    assign op_signed = (op_i == 3'd1) || (op_i == 3'd3);

    // done_q masks the still-presented instruction for one cycle after it completes.
    assign issue  = (state_q == IDLE) && start_i && !cancel_i && !done_q;
    assign accept = issue && (op_mul || op_div);
    assign fast   = FAST_MUL && op_mul;
    assign launch = accept && !fast;
    assign last   = (state_q == RUN) && (count_q == CW'(WIDTH - 1));

    // stall_o holds IF/ID/EX while high; the instruction advances in the first low cycle.
    assign stall_o = !rst && (launch || ((state_q == RUN) && !cancel_i));

    assign a_neg    = op_signed && a_i[WIDTH-1];
    assign b_neg    = op_signed && b_i[WIDTH-1];
    assign a_abs    = a_neg ? -a_i : a_i;
    assign b_abs    = b_neg ? -b_i : b_i;
    assign div_zero = op_div && (b_i == '0);

    assign a_ext     = op_signed ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    assign b_ext     = op_signed ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    assign fast_prod = a_ext * b_ext;

    // One iteration: shift-add multiply on {hi,lo}, or restoring divide step.
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    always_comb begin
        if (is_div_q) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_ge};
        end else begin
            {step_hi, step_lo} = {mul_sum, work_lo[WIDTH-1:1]};
        end
    end

    assign prod     = {step_hi, step_lo};
    assign prod_fix = neg_lo_q ? -prod : prod;
    assign res_hi   = is_div_q ? (neg_hi_q ? -step_hi : step_hi) : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div_q ? (neg_lo_q ? -step_lo : step_lo) : prod_fix[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = RUN;
            RUN:     if (cancel_i || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            count_q  <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                // A zero divisor runs unsigned on the raw dividend: LO=all ones, HI=a.
                work_hi  <= '0;
                work_lo  <= div_zero ? a_i : (op_div ? a_abs : b_abs);
                opnd_q   <= op_div ? b_abs : a_abs;
                is_div_q <= op_div;
                neg_lo_q <= !div_zero && (a_neg ^ b_neg);
                neg_hi_q <= op_div ? (!div_zero && a_neg) : (a_neg ^ b_neg);
                count_q  <= '0;
            end else if ((state_q == RUN) && !cancel_i) begin
                work_hi <= step_hi;
                work_lo <= step_lo;
                count_q <= count_q + 1'b1;
                if (last) begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
            end
            if (accept && fast) begin
                hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
                lo_q   <= fast_prod[WIDTH-1:0];
                done_q <= 1'b1;
            end
            if (issue && (op_i == 3'd5)) hi_q <= a_i;
            if (issue && (op_i == 3'd6)) lo_q <= a_i;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: an iterative instance and a FAST_MUL instance, checked every
// cycle against a countdown/arithmetic model, plus directed literal expectations.
module tb_muldiv_hilo;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        start_s;
    logic [2:0]        op_s;
    logic              cancel_s;
    logic [31:0]       a_s, b_s;
    logic [1:0]        stall_s, done_s;
    logic [1:0][31:0]  hi_s, lo_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_hilo #(.WIDTH(32), .FAST_MUL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start_s[0]), .op_i(op_s), .cancel_i(cancel_s),
        .a_i(a_s), .b_i(b_s), .stall_o(stall_s[0]), .hi_o(hi_s[0]), .lo_o(lo_s[0]),
        .done_o(done_s[0])
    );

    muldiv_hilo #(.WIDTH(32), .FAST_MUL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start_s[1]), .op_i(op_s), .cancel_i(cancel_s),
        .a_i(a_s), .b_i(b_s), .stall_o(stall_s[1]), .hi_o(hi_s[1]), .lo_o(lo_s[1]),
        .done_o(done_s[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {HI,LO} from the architectural definition of each operation.
    function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        model_res = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd1: begin sp = longint'(sa) * longint'(sb); model_res = sp; end
            3'd2: begin up = longint'(a) * longint'(b); model_res = up; end
            3'd3: begin
                if (b == 32'd0)                                 model_res = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model_res = {32'd0, a};
                else                                            model_res = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd4: begin
                if (b == 32'd0) model_res = {a, 32'hFFFFFFFF};
                else            model_res = {a % b, a / b};
            end
            default: model_res = '0;
        endcase
    endfunction

    // Cycle model: an iterative op is busy for 32 cycles after its accept edge.
    logic        m_valid = 1'b0;
    logic [1:0]  m_busy, m_done;
    int          m_rem [2];
    logic [31:0] m_hi [2], m_lo [2], p_hi [2], p_lo [2];
    logic        c_md, c_fast, c_go, c_stall, c_nd;
    logic [63:0] c_r;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            c_md    = (op_s >= 3'd1) && (op_s <= 3'd4);
            c_fast  = (k == 1) && ((op_s == 3'd1) || (op_s == 3'd2));
            c_go    = !m_busy[k] && start_s[k] && !cancel_s && !m_done[k];
            c_stall = !rst && ((c_go && c_md && !c_fast) || (m_busy[k] && !cancel_s));
            if (m_valid) begin
                chk($sformatf("m%0d.stall", k), 64'(stall_s[k]), 64'(c_stall));
                chk($sformatf("m%0d.hi", k), 64'(hi_s[k]), 64'(m_hi[k]));
                chk($sformatf("m%0d.lo", k), 64'(lo_s[k]), 64'(m_lo[k]));
                chk($sformatf("m%0d.done", k), 64'(done_s[k]), 64'(m_done[k]));
            end
            if (rst) begin
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_hi[k]   = '0;
                m_lo[k]   = '0;
            end else begin
                c_nd = 1'b0;
                if (m_busy[k]) begin
                    if (cancel_s) m_busy[k] = 1'b0;
                    else if (m_rem[k] == 1) begin
                        m_hi[k] = p_hi[k];
                        m_lo[k] = p_lo[k];
                        c_nd = 1'b1;
                        m_busy[k] = 1'b0;
                    end else m_rem[k]--;
                end else if (c_go) begin
                    if (c_md) begin
                        c_r = model_res(op_s, a_s, b_s);
                        if (c_fast) begin
                            {m_hi[k], m_lo[k]} = c_r;
                            c_nd = 1'b1;
                        end else begin
                            {p_hi[k], p_lo[k]} = c_r;
                            m_busy[k] = 1'b1;
                            m_rem[k] = 32;
                        end
                    end else if (op_s == 3'd5) m_hi[k] = a_s;
                    else if (op_s == 3'd6) m_lo[k] = a_s;
                end
                m_done[k] = c_nd;
            end
        end
        if (rst) m_valid = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an instruction and holds it while stalled, like the pipeline would.
    task automatic run_op(input int k, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, output int stalls, output logic done_seen);
        op_s = o;
        a_s  = av;
        b_s  = bv;
        start_s[k] = 1'b1;
        #1;
        stalls = 0;
        while (stall_s[k] && stalls < 100) begin
            stalls++;
            tick();
        end
        done_seen = done_s[k];
        tick();
        start_s[k] = 1'b0;
        op_s = 3'd0;
    endtask

    task automatic expect_op(input string name, input int k, input logic [2:0] o,
                             input logic [31:0] av, input logic [31:0] bv, input int exp_stalls,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   st;
        logic dn;
        run_op(k, o, av, bv, st, dn);
        chk({name, ".stalls"}, 64'(st), 64'(exp_stalls));
        chk({name, ".hi"}, 64'(hi_s[k]), 64'(exp_hi));
        chk({name, ".lo"}, 64'(lo_s[k]), 64'(exp_lo));
        if (exp_stalls > 0) begin
            chk({name, ".done_pulse"}, 64'(dn), 64'd1);
            chk({name, ".done_clr"}, 64'(done_s[k]), 64'd0);
        end else if (o <= 3'd4) begin
            chk({name, ".done_fast"}, 64'(done_s[k]), 64'd1);
        end else begin
            chk({name, ".done_mt"}, 64'(done_s[k]), 64'd0);
        end
        if (o <= 3'd4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_s = '0;
        op_s = '0;
        cancel_s = 1'b0;
        a_s = '0;
        b_s = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d.hi", k), 64'(hi_s[k]), 64'd0);
            chk($sformatf("rst%0d.lo", k), 64'(lo_s[k]), 64'd0);
            chk($sformatf("rst%0d.done", k), 64'(done_s[k]), 64'd0);
            chk($sformatf("rst%0d.stall", k), 64'(stall_s[k]), 64'd0);
        end
        tick();

        expect_op("multu", 0, 3'd2, 32'hFFFFFFFF, 32'h2, 33, 32'h00000001, 32'hFFFFFFFE);
        expect_op("mult", 0, 3'd1, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        expect_op("div", 0, 3'd3, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        expect_op("divu", 0, 3'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        expect_op("div_ovf", 0, 3'd3, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
        expect_op("divu_z", 0, 3'd4, 32'h1234, 32'h0, 33, 32'h1234, 32'hFFFFFFFF);
        expect_op("div_z", 0, 3'd3, 32'h80000005, 32'h0, 33, 32'h80000005, 32'hFFFFFFFF);
        expect_op("mthi", 0, 3'd5, 32'hA5A5A5A5, 32'h0, 0, 32'hA5A5A5A5, 32'hFFFFFFFF);
        expect_op("mtlo", 0, 3'd6, 32'h5A5A5A5A, 32'h0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A);
        tick();

        // Cancel a DIVU in its 10th RUN cycle, then a fresh DIVU the next cycle.
        op_s = 3'd4;
        a_s = 32'd1000;
        b_s = 32'd3;
        start_s[0] = 1'b1;
        repeat (10) tick();
        cancel_s = 1'b1;
        start_s[0] = 1'b0;
        #1;
        chk("cancel.stall", 64'(stall_s[0]), 64'd0);
        tick();
        cancel_s = 1'b0;
        chk("cancel.hi", 64'(hi_s[0]), 64'hA5A5A5A5);
        chk("cancel.lo", 64'(lo_s[0]), 64'h5A5A5A5A);
        chk("cancel.done", 64'(done_s[0]), 64'd0);
        expect_op("divu_after", 0, 3'd4, 32'hFFFFFFFF, 32'h10, 33, 32'h0000000F, 32'h0FFFFFFF);

        // Reset in the 5th RUN cycle of a MULT.
        op_s = 3'd1;
        a_s = 32'd5;
        b_s = 32'd5;
        start_s[0] = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        start_s[0] = 1'b0;
        #1;
        chk("rstrun.stall_in", 64'(stall_s[0]), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstrun.hi", 64'(hi_s[0]), 64'd0);
        chk("rstrun.lo", 64'(lo_s[0]), 64'd0);
        chk("rstrun.done", 64'(done_s[0]), 64'd0);
        chk("rstrun.stall", 64'(stall_s[0]), 64'd0);
        tick();

        expect_op("fmult", 1, 3'd1, 32'hFFFFFFFD, 32'd7, 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        expect_op("fmultu", 1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h00000001);
        expect_op("fdivu", 1, 3'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
